// File: rtl/data_ram_slave.sv
// rtl/data_ram_slave.sv - word-organised big-endian data RAM responder with ce/ack handshake
// Requests are served from live inputs; only the FSM state and wait counter are held internally.
module data_ram_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic enter_resp;

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic in_range;
    logic unused_addr_bits;

    assign word_idx         = mem_addr_i[DEPTH_LOG2+1:2];
    assign in_range         = (mem_addr_i >> (DEPTH_LOG2 + 2)) == 32'h0;
    assign unused_addr_bits = ^mem_addr_i[1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                // Dropping ce while waiting abandons the request without side effects.
                if (!mem_ce_i) begin
                    state_next = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            mem_data_o <= 32'h0;
            mem_ack_o  <= 1'b0;
            mem_err_o  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_ack_o <= enter_resp && in_range;
            mem_err_o <= enter_resp && !in_range;
            if (enter_resp && in_range && !mem_we_i) begin
                mem_data_o <= mem[word_idx];
            end
        end
    end

    // Array is deliberately left out of reset; sel bit b gates data bits [8b+7:8b].
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && in_range && mem_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel_i[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_slave.sv
// tb/tb_data_ram_slave.sv - self-checking bench for data_ram_slave at WAIT_STATES 0, 1 and 3
// Three instances share the request bus; each has its own ce and response signals.
module tb_data_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [2:0]  ce;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [3][16];
    logic [31:0] ref_rd  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata[0]),
        .mem_ack_o(ack[0]), .mem_err_o(err[0])
    );
    data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata[1]),
        .mem_ack_o(ack[1]), .mem_err_o(err[1])
    );
    data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata[2]),
        .mem_ack_o(ack[2]), .mem_err_o(err[2])
    );

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // Byte k of the word (byte address base+k) is enabled by sel[3-k] and lives in data[31-8k -: 8].
    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (s[3-k]) r[31-8*k -: 8] = d[31-8*k -: 8];
        end
        return r;
    endfunction

    task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output bit got_err,
                        output bit both, output logic [31:0] rd, output bit extra,
                        output int ack_cyc);
        we = w; addr = a; sel = s; wdata = d; ce[i] = 1'b1;
        lat = -1; got_err = 1'b0; both = 1'b0; rd = 32'hx; extra = 1'b0; ack_cyc = -1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack[i] || err[i]) begin
                lat = k; got_err = err[i]; both = ack[i] && err[i];
                rd = rdata[i]; ack_cyc = cyc;
                break;
            end
        end
        ce[i] = 1'b0;
        @(negedge clk);
        extra = ack[i] || err[i];
    endtask

    task automatic init_all();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        rst = 1'b1; ce = 3'b000; we = 1'b0; addr = 32'h0; sel = 4'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ref_rd[i] = 32'h0;
            for (int wd = 0; wd < 16; wd++) begin
                ref_mem[i][wd] = 32'hA5A5_0000 + 32'(i * 256 + wd);
                xact(i, 1'b1, 32'(wd * 4), 4'hF, ref_mem[i][wd], lat, e, b, rd, x, ac);
            end
        end
    endtask

    task automatic test_reset();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        rst = 1'b1; ce = 3'b111; we = 1'b1; addr = 32'h0; sel = 4'hF; wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ack[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_outputs inst=%0d cyc=%0d: ack=%b err=%b data=%h, required 0/0/00000000",
                             i, c, ack[i], err[i], rdata[i]);
                end
            end
        end
        rst = 1'b0; ce = 3'b000;
        for (int i = 0; i < 3; i++) ref_rd[i] = 32'h0;
        @(negedge clk);
        xact(1, 1'b0, 32'h0, 4'h0, 32'h0, lat, e, b, rd, x, ac);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || rd !== ref_mem[1][0]) begin
            n_bad++;
            $display("FAIL reset_no_write: lat=%0d err=%b data=%h, required lat=2 err=0 data=%h",
                     lat, e, rd, ref_mem[1][0]);
        end
        ref_rd[1] = ref_mem[1][0];
    endtask

    task automatic test_write_read();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        xact(1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, lat, e, b, rd, x, ac);
        ref_mem[1][4] = merge_bytes(ref_mem[1][4], 32'h1234_5678, 4'hF);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || x !== 1'b0 || rd !== ref_rd[1]) begin
            n_bad++;
            $display("FAIL write_ack: lat=%0d err=%b extra=%b data=%h, required lat=2 err=0 extra=0 data=%h",
                     lat, e, x, rd, ref_rd[1]);
        end
        xact(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, e, b, rd, x, ac);
        ref_rd[1] = ref_mem[1][4];
        n_cmp++;
        if (lat !== 2 || e !== 1'b0 || x !== 1'b0 || rd !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL read_back: lat=%0d err=%b extra=%b data=%h, required lat=2 err=0 extra=0 data=12345678",
                     lat, e, x, rd);
        end
    endtask

    task automatic test_byte_lanes();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        xact(1, 1'b1, 32'h10, 4'b0100, 32'h00AB_0000, lat, e, b, rd, x, ac);
        ref_mem[1][4] = merge_bytes(ref_mem[1][4], 32'h00AB_0000, 4'b0100);
        xact(1, 1'b0, 32'h10, 4'h0, 32'h0, lat, e, b, rd, x, ac);
        ref_rd[1] = ref_mem[1][4];
        n_cmp++;
        if (rd !== ref_mem[1][4] || rd !== 32'h12AB_5678) begin
            n_bad++;
            $display("FAIL lane_write: data=%h, required 12ab5678", rd);
        end
        xact(1, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, lat, e, b, rd, x, ac);
        n_cmp++;
        if (lat !== 2 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL sel0_ack: lat=%0d err=%b, required lat=2 err=0", lat, e);
        end
        xact(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, e, b, rd, x, ac);
        n_cmp++;
        if (rd !== ref_mem[1][4]) begin
            n_bad++;
            $display("FAIL sel0_unchanged: data=%h, required %h", rd, ref_mem[1][4]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        xact(1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, lat, e, b, rd, x, ac);
        n_cmp++;
        if (lat !== 2 || e !== 1'b1 || b !== 1'b0 || x !== 1'b0 || rd !== ref_rd[1]) begin
            n_bad++;
            $display("FAIL oor_read: lat=%0d err=%b both=%b extra=%b data=%h, required lat=2 err=1 both=0 extra=0 data=%h",
                     lat, e, b, x, rd, ref_rd[1]);
        end
        xact(1, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, lat, e, b, rd, x, ac);
        n_cmp++;
        if (lat !== 2 || e !== 1'b1 || b !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_write: lat=%0d err=%b both=%b, required lat=2 err=1 both=0", lat, e, b);
        end
        xact(1, 1'b0, 32'h0, 4'hF, 32'h0, lat, e, b, rd, x, ac);
        ref_rd[1] = ref_mem[1][0];
        n_cmp++;
        if (e !== 1'b0 || rd !== ref_mem[1][0]) begin
            n_bad++;
            $display("FAIL oor_no_alias: err=%b data=%h, required err=0 data=%h", e, rd, ref_mem[1][0]);
        end
    endtask

    task automatic test_abort();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h0BAD_0BAD; ce[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        ce[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_resp cyc=%0d: ack=%b err=%b, required 0/0", c, ack[2], err[2]);
            end
        end
        xact(2, 1'b0, 32'h20, 4'h0, 32'h0, lat, e, b, rd, x, ac);
        ref_rd[2] = ref_mem[2][8];
        n_cmp++;
        if (lat !== 4 || e !== 1'b0 || rd !== ref_mem[2][8]) begin
            n_bad++;
            $display("FAIL abort_after: lat=%0d err=%b data=%h, required lat=4 err=0 data=%h",
                     lat, e, rd, ref_mem[2][8]);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat, ac; bit e, b, x; logic [31:0] rd;
        we = 1'b1; addr = 32'h24; sel = 4'hF; wdata = 32'h5555_5555; ce[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_in_wait: ack=%b err=%b data=%h, required 0/0/00000000", ack[2], err[2], rdata[2]);
        end
        rst = 1'b0; ce[2] = 1'b0;
        for (int i = 0; i < 3; i++) ref_rd[i] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_wait_quiet cyc=%0d: ack=%b err=%b, required 0/0", c, ack[2], err[2]);
            end
        end
        xact(2, 1'b0, 32'h24, 4'h0, 32'h0, lat, e, b, rd, x, ac);
        ref_rd[2] = ref_mem[2][9];
        n_cmp++;
        if (lat !== 4 || rd !== ref_mem[2][9]) begin
            n_bad++;
            $display("FAIL rst_wait_no_write: lat=%0d data=%h, required lat=4 data=%h", lat, rd, ref_mem[2][9]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ac, prev_ac; bit e, b, x; logic [31:0] rd;
        prev_ac = -1;
        for (int k = 0; k < 3; k++) begin
            xact(0, 1'b0, 32'(k * 4), 4'hF, 32'h0, lat, e, b, rd, x, ac);
            ref_rd[0] = ref_mem[0][k];
            n_cmp++;
            if (lat !== 1 || e !== 1'b0 || x !== 1'b0 || rd !== ref_mem[0][k]) begin
                n_bad++;
                $display("FAIL b2b_read%0d: lat=%0d err=%b extra=%b data=%h, required lat=1 err=0 extra=0 data=%h",
                         k, lat, e, x, rd, ref_mem[0][k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (ac - prev_ac !== 2) begin
                    n_bad++;
                    $display("FAIL b2b_interval%0d: got %0d cycles, required 2", k, ac - prev_ac);
                end
            end
            prev_ac = ac;
        end
    endtask

    task automatic test_random();
        int lat, ac, i, wd; bit w, oor, e, b, x; logic [31:0] a, d, rd, exp_rd;
        logic [3:0] s;
        for (int n = 0; n < 80; n++) begin
            i   = int'($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            oor = ($urandom_range(0, 5) == 0);
            wd  = int'($urandom_range(0, 15));
            s   = 4'($urandom);
            d   = $urandom;
            a   = 32'(wd * 4) | 32'($urandom_range(0, 3));
            if (oor) a = a | (32'($urandom_range(1, 32'hFFFFF)) << 12);
            xact(i, w, a, s, d, lat, e, b, rd, x, ac);
            if (!oor && w) ref_mem[i][wd] = merge_bytes(ref_mem[i][wd], d, s);
            if (!oor && !w) ref_rd[i] = ref_mem[i][wd];
            exp_rd = ref_rd[i];
            n_cmp++;
            if (lat !== ws_of(i) + 1 || e !== oor || b !== 1'b0 || x !== 1'b0 || rd !== exp_rd) begin
                n_bad++;
                $display("FAIL rand%0d inst=%0d we=%b addr=%h: lat=%0d err=%b both=%b extra=%b data=%h, required lat=%0d err=%b both=0 extra=0 data=%h",
                         n, i, w, a, lat, e, b, x, rd, ws_of(i) + 1, oor, exp_rd);
            end
        end
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 16; k++) begin
                xact(j, 1'b0, 32'(k * 4), 4'h0, 32'h0, lat, e, b, rd, x, ac);
                ref_rd[j] = ref_mem[j][k];
                n_cmp++;
                if (rd !== ref_mem[j][k]) begin
                    n_bad++;
                    $display("FAIL rand_final inst=%0d word=%0d: data=%h, required %h", j, k, rd, ref_mem[j][k]);
                end
            end
        end
    endtask

    initial begin
        init_all();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_abort();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
